i2c_master_arbiter: RTL

I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

---
 rtl/i2c_arb_defs.sv | 26 ++
 rtl/i2c_rr_pick.sv | 36 +++
 rtl/i2c_master_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/i2c_arb_defs.sv
// Shared FSM encodings, field widths and parameter defaults for the I2C master arbiter.
package i2c_arb_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int unsigned DEF_CMD_HOLD       = 2;
    localparam int unsigned DEF_WR_CYCLES      = 48;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 200;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;

    // Command captured from the winning requester at arbitration time.
    typedef struct packed {
        logic              read;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: searches upward from last_owner+1 with wrap.
module i2c_rr_pick #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_owner,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] winner_idx
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = 32'(last_owner) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found            = 1'b1;
                winner[cand_idx] = 1'b1;
                winner_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one i2c_master between N_REQ requesters, one transaction at a time,
// with round-robin arbitration, write-completion timing and a watchdog.
module i2c_master_arbiter
    import i2c_arb_defs::*;
#(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned CMD_HOLD       = DEF_CMD_HOLD,
    parameter int unsigned WR_CYCLES      = DEF_WR_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_read,
    input  logic [ADDR_W*N_REQ-1:0] req_addr,
    input  logic [DATA_W*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_error,
    output logic                    rsp_timeout,
    output logic [ADDR_W-1:0]       m_slave_address,
    output logic                    m_read,
    output logic [DATA_W-1:0]       m_data_send,
    output logic                    m_data_send_enable,
    input  logic [DATA_W-1:0]       m_data_receive,
    input  logic                    m_data_receive_enable,
    input  logic                    m_error
);

    localparam int unsigned      IDX_W      = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] ISSUE_LAST = CNT_W'(CMD_HOLD - 1);
    localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    cmd_t              cmd, cmd_nx, win_cmd_c;
    logic [IDX_W-1:0]  owner, last_owner;
    logic              err_lat;
    logic [N_REQ-1:0]  win_oh_c;
    logic [IDX_W-1:0]  win_idx_c;
    logic              done_c, res_err_c, res_to_c;
    logic [DATA_W-1:0] res_rdata_c;
    logic              arb_c, issue_nx_c;

    i2c_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req),
        .last_owner (last_owner),
        .winner     (win_oh_c),
        .winner_idx (win_idx_c)
    );

    // Mux out the winner's command fields.
    always_comb begin
        win_cmd_c = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (win_oh_c[i]) begin
                win_cmd_c.read  = req_read[i];
                win_cmd_c.addr  = req_addr[ADDR_W*i +: ADDR_W];
                win_cmd_c.wdata = req_wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        cmd_nx      = cmd;
        done_c      = 1'b0;
        res_err_c   = 1'b0;
        res_to_c    = 1'b0;
        res_rdata_c = '0;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_nx = ST_ISSUE;
                    cnt_nx   = '0;
                    cmd_nx   = win_cmd_c;
                end
            end
            ST_ISSUE: begin
                if (cnt == ISSUE_LAST) begin
                    state_nx = ST_WAIT;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                cnt_nx = cnt + CNT_W'(1);
                // Completion sources in priority order.
                if (m_error || err_lat) begin
                    done_c    = 1'b1;
                    res_err_c = 1'b1;
                end else if (cmd.read && m_data_receive_enable) begin
                    done_c      = 1'b1;
                    res_rdata_c = m_data_receive;
                end else if (!cmd.read && cnt == WR_LAST) begin
                    done_c = 1'b1;
                end else if (cnt == TO_LAST) begin
                    done_c   = 1'b1;
                    res_to_c = 1'b1;
                end
                if (done_c) begin
                    state_nx = ST_RESP;
                    cnt_nx   = '0;
                end
            end
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign arb_c      = (state == ST_IDLE) && (|req);
    assign issue_nx_c = (state_nx == ST_ISSUE);

    // State, captured command and registered outputs (driven from next-state).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            cmd                <= '0;
            owner              <= '0;
            last_owner         <= IDX_W'(N_REQ - 1);
            err_lat            <= 1'b0;
            gnt                <= '0;
            rsp_valid          <= '0;
            rsp_rdata          <= '0;
            rsp_error          <= 1'b0;
            rsp_timeout        <= 1'b0;
            m_slave_address    <= '0;
            m_read             <= 1'b0;
            m_data_send        <= '0;
            m_data_send_enable <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            cmd   <= cmd_nx;
            if (state == ST_IDLE) begin
                err_lat <= 1'b0;
            end else if (state == ST_ISSUE && m_error) begin
                err_lat <= 1'b1;
            end
            if (arb_c) begin
                owner <= win_idx_c;
            end
            if (state == ST_RESP) begin
                last_owner <= owner;
            end
            gnt                <= arb_c ? win_oh_c : '0;
            rsp_valid          <= done_c ? (N_REQ'(1) << owner) : '0;
            rsp_rdata          <= res_rdata_c;
            rsp_error          <= res_err_c;
            rsp_timeout        <= res_to_c;
            m_slave_address    <= issue_nx_c ? cmd_nx.addr : '0;
            m_read             <= issue_nx_c & cmd_nx.read;
            m_data_send        <= (issue_nx_c && !cmd_nx.read) ? cmd_nx.wdata : '0;
            m_data_send_enable <= issue_nx_c & ~cmd_nx.read;
        end
    end

endmodule
